countdown_display: RTL

// - Downstream consumer of the traffic light controller outputs; drives a 2-digit multiplexed 7-seg showing seconds left in current interval.
// - Tracks its own remaining-seconds count from Start_Timer/Value/OneHz/Expired, converts it to decimal and scans two digits.
// - Purely observational: it never feeds back into the FSM or the timer.

---
 rtl/traffic_pkg.sv | 19 +
 rtl/seg7_decoder.sv | 17 +
 rtl/countdown_display.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic-light display path: display FSM states,
// digit-select values and active-low 7-segment patterns ({g,f,e,d,c,b,a}).
package traffic_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic SEL_ONES = 1'b0;
    localparam logic SEL_TENS = 1'b1;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_DIGIT [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low 7-segment pattern; codes above 9
// decode to an all-off (blank) digit.
module seg7_decoder
    import traffic_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (digit_i <= 4'd9) begin
            seg_o = SEG_DIGIT[digit_i];
        end
    end

endmodule

// File: rtl/countdown_display.sv
// Seconds-left tracker and 2-digit multiplexed 7-seg driver for the traffic
// light controller. Optional walk-signal blink enabled by macro WALK_FLASH_EN.
//
// state   | meaning
// IDLE    | after reset, no interval started; display blanked
// RUN     | interval counting down; digits shown
// DONE    | interval over (count at 0); shows "0"
module countdown_display
    import traffic_pkg::*;
#(
    parameter int REFRESH_DIV  = 1000,
    parameter int FLASH_THRESH = 3
) (
    input  logic       clk,
    input  logic       Sync_Reset,
    input  logic       Start_Timer,
    input  logic [3:0] Value,
    input  logic       OneHz,
    input  logic       Expired,
    input  logic [6:0] LEDs,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic [3:0] Remaining
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] REFRESH_TC = CNT_W'(REFRESH_DIV - 1);

    logic [1:0]       state_q, state_d;
    logic [3:0]       remaining_q, remaining_d;
    logic [CNT_W-1:0] refresh_q, refresh_d;
    logic             sel_q, sel_d;
    logic [6:0]       seg_q, seg_d;
    logic [1:0]       an_q, an_d;
    logic             tens;
    logic [3:0]       ones;
    logic [3:0]       disp_digit;
    logic [6:0]       dec_seg;
    logic             flash_blank;

    always_comb begin
        remaining_d = remaining_q;
        if (Start_Timer) begin
            remaining_d = Value;
        end else if (Expired) begin
            remaining_d = '0;
        end else if (OneHz && (remaining_q != 4'd0)) begin
            remaining_d = remaining_q - 4'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Start_Timer) begin
                    state_d = (Value == 4'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (Start_Timer) begin
                    state_d = (Value == 4'd0) ? ST_DONE : ST_RUN;
                end else if (remaining_d == 4'd0) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Scan keeps running in every state so the digit phase is independent of the count.
    always_comb begin
        refresh_d = refresh_q + CNT_W'(1);
        sel_d     = sel_q;
        if (refresh_q == REFRESH_TC) begin
            refresh_d = '0;
            sel_d     = ~sel_q;
        end
    end

    assign tens       = (remaining_q >= 4'd10);
    assign ones       = tens ? (remaining_q - 4'd10) : remaining_q;
    assign disp_digit = (sel_q == SEL_TENS) ? (tens ? 4'd1 : 4'hF) : ones;

    seg7_decoder u_seg7_decoder (
        .digit_i (disp_digit),
        .seg_o   (dec_seg)
    );

`ifdef WALK_FLASH_EN
    logic phase_q, phase_d;
    logic unused_leds;

    assign unused_leds = ^LEDs[6:1];

    always_comb begin
        phase_d = phase_q;
        if (Start_Timer) begin
            phase_d = 1'b0;
        end else if (OneHz) begin
            phase_d = ~phase_q;
        end
    end

    assign flash_blank = LEDs[0] && (state_q == ST_RUN) &&
                         (int'(remaining_q) <= FLASH_THRESH) && phase_q;

    always_ff @(posedge clk) begin
        if (Sync_Reset) begin
            phase_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg  = (^LEDs) ^ (FLASH_THRESH != 0);
    assign flash_blank = 1'b0;
`endif

    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = 2'b11;
        if (state_q != ST_IDLE) begin
            seg_d = dec_seg;
            an_d  = (sel_q == SEL_TENS) ? 2'b01 : 2'b10;
            if (flash_blank) begin
                an_d = 2'b11;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Sync_Reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            refresh_q   <= '0;
            sel_q       <= SEL_ONES;
            seg_q       <= SEG_BLANK;
            an_q        <= 2'b11;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            refresh_q   <= refresh_d;
            sel_q       <= sel_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign seg       = seg_q;
    assign an        = an_q;
    assign Remaining = remaining_q;

endmodule
